// File: rtl/vga_glyph_pkg.sv
// vga_glyph_pkg: shared widths and frame-sequencer state encoding
package vga_glyph_pkg;
    localparam int MODE_W = 2;
    localparam int PAL_W  = 2;
    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;
endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: parameterised-width two-flop synchroniser
module sync_ff2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q, sync_q;
    // first flop may go metastable, second one hands a settled value on
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    assign q_o = sync_q;
endmodule

// File: rtl/glyph_frame_sequencer.sv
// glyph_frame_sequencer: mode/palette sync, frame counter and timing-generator resync control
module glyph_frame_sequencer
    import vga_glyph_pkg::*;
#(
    parameter logic SYNC_POL      = 1'b0,
    parameter int   RST_CYCLES    = 4,
    parameter int   SETTLE_FRAMES = 2,
    parameter int   FRAME_W       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync_in,
    input  logic [MODE_W-1:0]  mode_req,
    input  logic [PAL_W-1:0]   pal_req,
    input  logic               pause,
    output logic [MODE_W-1:0]  mode,
    output logic [PAL_W-1:0]   pal,
    output logic               timing_reset,
    output logic               blank,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               intro_done
);
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE_FRAMES - 1);

    logic [MODE_W-1:0]  mode_s, mode_q, mode_d;
    logic [PAL_W-1:0]   pal_s, pal_q, pal_d;
    logic               pause_s;
    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               vs_q, vs_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_q, tick_d;
    logic               intro_q, intro_d;
    logic               tres_q, tres_d;
    logic               blank_q, blank_d;
    logic               evt;

    sync_ff2 #(.W(MODE_W)) u_mode_sync  (.clk(clk), .reset(reset), .d_i(mode_req), .q_o(mode_s));
    sync_ff2 #(.W(PAL_W))  u_pal_sync   (.clk(clk), .reset(reset), .d_i(pal_req),  .q_o(pal_s));
    sync_ff2 #(.W(1))      u_pause_sync (.clk(clk), .reset(reset), .d_i(pause),    .q_o(pause_s));

    // state register and all registered outputs
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= RESYNC;
            cnt_q   <= '0;
            mode_q  <= '0;
            pal_q   <= '0;
            vs_q    <= SYNC_POL;
            frame_q <= '0;
            tick_q  <= 1'b0;
            intro_q <= 1'b0;
            tres_q  <= 1'b1;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pal_q   <= pal_d;
            vs_q    <= vs_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            intro_q <= intro_d;
            tres_q  <= tres_d;
            blank_q <= blank_d;
        end

    // vsync event, frame counter and the resync/settle/run/drain sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        evt     = vsync_in == SYNC_POL && vs_q != SYNC_POL && state_q != RESYNC;
        // holding the previous sample at the active level in RESYNC hides the
        // first edge after leaving it, so a sync already asserted is not a frame
        vs_d    = (state_q == RESYNC) ? SYNC_POL : vsync_in;
        pal_d   = evt ? pal_s : pal_q;
        frame_d = (evt && !pause_s) ? frame_q + FRAME_W'(1) : frame_q;
        intro_d = intro_q | (evt && !pause_s && &frame_q);
        tick_d  = evt;
        case (state_q)
            RESYNC:
                if (cnt_q == RST_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    mode_d  = mode_s;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            SETTLE:
                if (evt) begin
                    if (cnt_q == SET_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            RUN:
                if (mode_s != mode_q) state_d = DRAIN;
            DRAIN:
                if (evt) begin
                    state_d = RESYNC;
                    cnt_d   = '0;
                end
            default: state_d = RESYNC;
        endcase
        tres_d  = state_d == RESYNC;
        blank_d = state_d == RESYNC || state_d == SETTLE;
    end

    assign mode         = mode_q;
    assign pal          = pal_q;
    assign timing_reset = tres_q;
    assign blank        = blank_q;
    assign frame        = frame_q;
    assign frame_tick   = tick_q;
    assign intro_done   = intro_q;
endmodule

// File: tb/tb_glyph_frame_sequencer.sv
// tb_glyph_frame_sequencer: directed self-checking bench for the frame sequencer
module tb_glyph_frame_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       vsync_in;
    logic [1:0] mode_req;
    logic [1:0] pal_req;
    logic       pause;
    logic [1:0] mode;
    logic [1:0] pal;
    logic       timing_reset;
    logic       blank;
    logic [9:0] frame;
    logic       frame_tick;
    logic       intro_done;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_frame = '0;
    logic       t1, t2;

    glyph_frame_sequencer dut (
        .clk(clk), .reset(reset), .vsync_in(vsync_in), .mode_req(mode_req),
        .pal_req(pal_req), .pause(pause), .mode(mode), .pal(pal),
        .timing_reset(timing_reset), .blank(blank), .frame(frame),
        .frame_tick(frame_tick), .intro_done(intro_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one vsync falling edge: t1 is frame_tick right after the event edge, t2 one cycle later
    task automatic pulse(input bit counted);
        vsync_in = 1'b0;
        tick();
        t1 = frame_tick;
        vsync_in = 1'b1;
        tick();
        t2 = frame_tick;
        if (counted) exp_frame = exp_frame + 10'd1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tres"},  32'(timing_reset), 1);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_mode"},  32'(mode), 0);
        chk({tag, "_pal"},   32'(pal), 0);
        chk({tag, "_frame"}, 32'(frame), 0);
        chk({tag, "_tick"},  32'(frame_tick), 0);
        chk({tag, "_intro"}, 32'(intro_done), 0);
    endtask

    initial begin
        reset = 1'b1; vsync_in = 1'b1; mode_req = 2'd2; pal_req = 2'd0; pause = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        // 1: reset release, RESYNC for 4 cycles, mode capture, settle for 2 frames
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rel_tres_hi", 32'(timing_reset), 1);
        end
        tick();
        chk("rel_tres_lo", 32'(timing_reset), 0);
        chk("rel_mode", 32'(mode), 2);
        chk("rel_blank_settle", 32'(blank), 1);
        repeat (3) tick();
        pulse(1'b1);
        chk("settle1_tick", 32'(t1), 1);
        chk("settle1_blank", 32'(blank), 1);
        pulse(1'b1);
        chk("settle2_blank", 32'(blank), 0);
        chk("settle_frame", 32'(frame), 32'(exp_frame));
        chk("settle_pal", 32'(pal), 0);
        // 2: five ticks in RUN, palette follows at the first tick
        pal_req = 2'd3;
        repeat (3) tick();
        chk("pal_before_tick", 32'(pal), 0);
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1);
            chk("run_tick_hi", 32'(t1), 1);
            chk("run_tick_lo", 32'(t2), 0);
            if (i == 0) chk("run_pal", 32'(pal), 3);
        end
        chk("run_frame", 32'(frame), 32'(exp_frame));
        // 3: wrap of the frame counter sets intro_done
        while (exp_frame != 10'd1022) pulse(1'b1);
        chk("pre_frame", 32'(frame), 1022);
        pulse(1'b1);
        chk("wrap_1023", 32'(frame), 1023);
        chk("wrap_intro_lo", 32'(intro_done), 0);
        pulse(1'b1);
        chk("wrap_zero", 32'(frame), 0);
        chk("wrap_intro_hi", 32'(intro_done), 1);
        for (int i = 0; i < 3; i++) pulse(1'b1);
        chk("intro_sticky", 32'(intro_done), 1);
        chk("post_wrap_frame", 32'(frame), 3);
        // 4: pause freezes the counter but not the tick
        pause = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0);
            chk("pause_tick", 32'(t1), 1);
            chk("pause_frame", 32'(frame), 3);
        end
        pause = 1'b0;
        repeat (3) tick();
        pulse(1'b1);
        chk("unpause_frame", 32'(frame), 4);
        // 5: mode change 2 -> 1: drain, resync, settle, run
        mode_req = 2'd1;
        tick(); tick();
        chk("pre_drain_state", 32'(dut.state_q), 2);
        tick();
        chk("drain_state", 32'(dut.state_q), 3);
        chk("drain_blank", 32'(blank), 0);
        chk("drain_tres", 32'(timing_reset), 0);
        vsync_in = 1'b0;
        tick();
        exp_frame = exp_frame + 10'd1;
        chk("drain_evt_tick", 32'(frame_tick), 1);
        chk("resync_tres", 32'(timing_reset), 1);
        chk("resync_blank", 32'(blank), 1);
        chk("resync_mode_old", 32'(mode), 2);
        vsync_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("resync_tres_hold", 32'(timing_reset), 1);
        end
        tick();
        chk("resync_tres_end", 32'(timing_reset), 0);
        chk("resync_mode_new", 32'(mode), 1);
        repeat (2) tick();
        pulse(1'b1);
        chk("resettle1_blank", 32'(blank), 1);
        pulse(1'b1);
        chk("resettle2_blank", 32'(blank), 0);
        chk("rerun_state", 32'(dut.state_q), 2);
        chk("rerun_frame", 32'(frame), 32'(exp_frame));
        // 6: reset asserted mid-SETTLE, then a vsync pulse inside RESYNC
        mode_req = 2'd3;
        repeat (3) tick();
        pulse(1'b1);
        repeat (6) tick();
        pulse(1'b1);
        chk("mid_settle_state", 32'(dut.state_q), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        reset = 1'b0;
        vsync_in = 1'b0;
        tick();
        chk("resync_vs_tick0", 32'(frame_tick), 0);
        vsync_in = 1'b1;
        tick();
        chk("resync_vs_tick1", 32'(frame_tick), 0);
        chk("resync_vs_frame", 32'(frame), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
